draw_cmd_exec: RTL and testbench
================================

Name: draw_cmd_exec

Overview:
- Consumer end of the 32-bit draw-command stream (`cmd`/`cmd_vld`) produced by the game cores.
- Buffers incoming words, because the producer has no backpressure.
- Executes tile-level ops directly into the logic-grid framebuffer write port.
- Pairs two-word physical-coordinate ops (line, char) and forwards them as 64-bit overlay commands to the pixel renderer over a valid/ready handshake.

Parameters:
- H_LOGIC_WIDTH, 5, logic x coordinate width
- V_LOGIC_WIDTH, 5, logic y coordinate width
- H_LOGIC_MAX, 5'd31, largest legal logic x
- V_LOGIC_MAX, 5'd23, largest legal logic y
- COLOR_ID_WIDTH, 8, color index width
- FIFO_DEPTH, 16, input FIFO entries (power of 2)
- FIFO_AW, 4, log2(FIFO_DEPTH)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd  in  32  draw command word
- cmd_vld  in  1  cmd valid; one word per high cycle, no ready
- fb_we  out  1  framebuffer write strobe
- fb_addr  out  H_LOGIC_WIDTH+V_LOGIC_WIDTH  tile address {y,x}
- fb_wdata  out  COLOR_ID_WIDTH  tile color
- ovl_cmd  out  64  {word0,word1} of paired op
- ovl_vld  out  1  overlay command valid
- ovl_rdy  in  1  renderer ready
- busy  out  1  FIFO non-empty or FSM not IDLE
- overflow  out  1  sticky: word dropped on full FIFO
- err_cmd  out  1  sticky: unknown opcode or broken pair

Behaviour:
- Reset:
  - all outputs 0; FIFO emptied; FSM to IDLE; sticky flags cleared.
  - Reset mid-fill or mid-handshake aborts with no further writes.
- Opcode is cmd[31:28]. Word formats:
  - 0x0 point: x=[27:23], y=[22:18], color=[17:10].
  - 0x1 fill: x0=[27:23], y0=[22:18], x1=[17:13], y1=[12:8], color=[7:0].
  - 0x9 line, 0xA char: two words; bit[0]=0 first word, bit[0]=1 second word.
- FIFO:
  - push on cmd_vld when not full.
  - cmd_vld while full: word dropped, overflow set. Fullness is judged before a same-cycle pop.
  - Show-ahead read.
- FSM states: IDLE, POINT, FILL, PAIR, OVL.
- IDLE:
  - FIFO non-empty: pop into cur register, decode.
  - 0x0 -> POINT. 0x1 -> FILL.
  - 0x9/0xA with bit0=0 -> PAIR (hold word0).
  - 0x9/0xA with bit0=1 -> err_cmd, discard, stay IDLE.
  - Other opcodes -> err_cmd, discard, stay IDLE.
- POINT:
  - registered write: fb_we=1 one cycle, fb_addr={y,x}, fb_wdata=color.
  - Then IDLE.
  - x>H_LOGIC_MAX or y>V_LOGIC_MAX: no write, no error.
- FILL:
  - bounds normalised to xmin/xmax/ymin/ymax (swap if x1<x0 or y1<y0).
  - raster order, x inner; one write per cycle; fb_we continuous.
  - Cells outside the legal range are skipped (no strobe), and still cost one cycle.
  - Done after (xmax,ymax) -> IDLE.
- PAIR:
  - waits for next FIFO word.
  - Same opcode with bit0=1 -> latch as word1, go to OVL.
  - Otherwise err_cmd, drop word0, and re-decode the new word as in IDLE, in the same cycle.
- OVL:
  - ovl_vld=1, ovl_cmd={word0,word1} held stable until ovl_vld&ovl_rdy.
  - Then ovl_vld=0 next cycle, IDLE.
  - FIFO keeps accepting words meanwhile.
- Latency:
  - point word pushed into an empty FIFO at edge k, FSM idle: fb_we high for the cycle after edge k+2.
  - Back-to-back points: one write per 2 cycles (IDLE+POINT).
- fb_addr/fb_wdata hold their last values when fb_we=0.

Decomposition:
- Shared package draw_cmd_pkg:
  - opcode constants OP_POINT=4'h0, OP_FILL=4'h1, OP_LINE=4'h9, OP_CHAR=4'hA.
  - field bit positions.
  - CMD_WIDTH=32.
  - FSM state encoding.
- One sub-module: draw_cmd_fifo (synchronous, show-ahead, full/empty, parameterised depth/width).
- Decode and FSM stay in draw_cmd_exec.

Test Plan:
- Point {0x0,x=3,y=5,0x0F} into idle block -> single fb_we at edge k+2, fb_addr=0x0A3, fb_wdata=0x0F.
- Fill {0x1,0,0,31,23,0xFF} -> 768 consecutive fb_we cycles, addresses 0x000..0x2FF in raster order, all data 0xFF, busy falls afterwards.
- Char pair 0xA (bit0=0) then 0xA (bit0=1), ovl_rdy low 5 cycles -> ovl_vld held 5+ cycles with ovl_cmd stable, drops one cycle after ready; no fb_we.
- Line word0 followed by point word -> err_cmd=1, no ovl_vld, point still written; then opcode 0x5 -> discarded, err_cmd stays 1.
- 20 back-to-back cmd_vld during a full-screen fill -> first 16 words accepted, overflow=1, the 16 buffered commands all executed in order after the fill.
- rst asserted mid-fill at cell 100 -> next cycle fb_we=0, busy=0, FIFO empty; a new point executes normally after reset.

Source files
------------

// File: rtl/draw_cmd_pkg.sv
// Shared definitions for the draw-command consumer: opcodes, word field positions,
// FSM encoding and the first-word decode used by the executor.
package draw_cmd_pkg;

  localparam int CMD_WIDTH = 32;

  localparam logic [3:0] OP_POINT = 4'h0;
  localparam logic [3:0] OP_FILL  = 4'h1;
  localparam logic [3:0] OP_LINE  = 4'h9;
  localparam logic [3:0] OP_CHAR  = 4'hA;

  localparam int OP_HI    = 31;
  localparam int OP_LO    = 28;
  localparam int PT_X_LO  = 23;
  localparam int PT_Y_LO  = 18;
  localparam int PT_C_LO  = 10;
  localparam int FL_X0_LO = 23;
  localparam int FL_Y0_LO = 18;
  localparam int FL_X1_LO = 13;
  localparam int FL_Y1_LO = 8;
  localparam int FL_C_LO  = 0;
  localparam int PAIR_BIT = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POINT,
    S_FILL,
    S_PAIR,
    S_OVL
  } state_t;

  // S_IDLE as a result means the word is discarded as an error.
  function automatic state_t decode_op(input logic [CMD_WIDTH-1:0] w);
    case (w[OP_HI:OP_LO])
      OP_POINT:         return S_POINT;
      OP_FILL:          return S_FILL;
      OP_LINE, OP_CHAR: return w[PAIR_BIT] ? S_IDLE : S_PAIR;
      default:          return S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/draw_cmd_fifo.sv
// Synchronous show-ahead FIFO: the head word is visible on rdata whenever not empty.
module draw_cmd_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // Fullness is taken before any same-cycle pop, so a full FIFO drops the word.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/draw_cmd_exec.sv
// Draw-command executor: buffers the command stream, writes point/fill tiles into the
// logic-grid framebuffer and forwards paired line/char words to the overlay renderer.
module draw_cmd_exec
  import draw_cmd_pkg::*;
#(
  parameter int                       H_LOGIC_WIDTH  = 5,
  parameter int                       V_LOGIC_WIDTH  = 5,
  parameter logic [H_LOGIC_WIDTH-1:0] H_LOGIC_MAX    = 5'd31,
  parameter logic [V_LOGIC_WIDTH-1:0] V_LOGIC_MAX    = 5'd23,
  parameter int                       COLOR_ID_WIDTH = 8,
  parameter int                       FIFO_DEPTH     = 16,
  parameter int                       FIFO_AW        = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [31:0]                            cmd,
  input  logic                                   cmd_vld,
  output logic                                   fb_we,
  output logic [H_LOGIC_WIDTH+V_LOGIC_WIDTH-1:0] fb_addr,
  output logic [COLOR_ID_WIDTH-1:0]              fb_wdata,
  output logic [63:0]                            ovl_cmd,
  output logic                                   ovl_vld,
  input  logic                                   ovl_rdy,
  output logic                                   busy,
  output logic                                   overflow,
  output logic                                   err_cmd
);

  localparam int HW = H_LOGIC_WIDTH;
  localparam int VW = V_LOGIC_WIDTH;
  localparam int CW = COLOR_ID_WIDTH;

  state_t               state;
  state_t               state_nxt;
  state_t               dec_state;
  logic [CMD_WIDTH-1:0] fifo_data;
  logic [CMD_WIDTH-1:0] cur;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 fifo_pop;
  logic                 load_cur;
  logic                 load_ovl;
  logic                 err_set;
  logic                 head_is_second;
  logic [HW-1:0]        fx0, fx1, cx, xmin, xmax;
  logic [VW-1:0]        fy0, fy1, cy, ymax;
  logic [HW-1:0]        px;
  logic [VW-1:0]        py;
  logic                 pt_legal;
  logic                 fill_legal;
  logic                 fill_last;

  draw_cmd_fifo #(
    .WIDTH (CMD_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_vld),
    .wdata (cmd),
    .pop   (fifo_pop),
    .rdata (fifo_data),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign dec_state      = decode_op(fifo_data);
  assign head_is_second = (fifo_data[OP_HI:OP_LO] == cur[OP_HI:OP_LO]) && fifo_data[PAIR_BIT];

  assign fx0 = fifo_data[FL_X0_LO +: HW];
  assign fy0 = fifo_data[FL_Y0_LO +: VW];
  assign fx1 = fifo_data[FL_X1_LO +: HW];
  assign fy1 = fifo_data[FL_Y1_LO +: VW];

  assign px         = cur[PT_X_LO +: HW];
  assign py         = cur[PT_Y_LO +: VW];
  assign pt_legal   = (px <= H_LOGIC_MAX) && (py <= V_LOGIC_MAX);
  assign fill_legal = (cx <= H_LOGIC_MAX) && (cy <= V_LOGIC_MAX);
  assign fill_last  = (cx == xmax) && (cy == ymax);

  assign ovl_vld = (state == S_OVL);
  assign busy    = !fifo_empty || (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    load_cur  = 1'b0;
    load_ovl  = 1'b0;
    err_set   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          load_cur  = 1'b1;
          state_nxt = dec_state;
          err_set   = (dec_state == S_IDLE);
        end
      end
      S_POINT: state_nxt = S_IDLE;
      S_FILL: begin
        if (fill_last) state_nxt = S_IDLE;
      end
      S_PAIR: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (head_is_second) begin
            load_ovl  = 1'b1;
            state_nxt = S_OVL;
          end else begin
            // Broken pair: word0 is dropped and the new word is decoded as if from IDLE.
            err_set   = 1'b1;
            load_cur  = 1'b1;
            state_nxt = dec_state;
          end
        end
      end
      S_OVL: begin
        if (ovl_rdy) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Fill bounds are normalised when the word is taken, so the raster walk only counts up.
  always_ff @(posedge clk) begin
    if (load_cur) begin
      cur  <= fifo_data;
      xmin <= (fx1 < fx0) ? fx1 : fx0;
      xmax <= (fx1 < fx0) ? fx0 : fx1;
      cx   <= (fx1 < fx0) ? fx1 : fx0;
      cy   <= (fy1 < fy0) ? fy1 : fy0;
      ymax <= (fy1 < fy0) ? fy0 : fy1;
    end else if (state == S_FILL) begin
      if (cx == xmax) begin
        cx <= xmin;
        cy <= cy + 1'b1;
      end else begin
        cx <= cx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      fb_we    <= 1'b0;
      fb_addr  <= '0;
      fb_wdata <= '0;
      ovl_cmd  <= '0;
      overflow <= 1'b0;
      err_cmd  <= 1'b0;
    end else begin
      state <= state_nxt;
      fb_we <= 1'b0;
      if (state == S_POINT && pt_legal) begin
        fb_we    <= 1'b1;
        fb_addr  <= {py, px};
        fb_wdata <= cur[PT_C_LO +: CW];
      end
      if (state == S_FILL && fill_legal) begin
        fb_we    <= 1'b1;
        fb_addr  <= {cy, cx};
        fb_wdata <= cur[FL_C_LO +: CW];
      end
      if (load_ovl) ovl_cmd <= {cur, fifo_data};
      if (cmd_vld && fifo_full) overflow <= 1'b1;
      if (err_set) err_cmd <= 1'b1;
    end
  end

endmodule

// File: tb/tb_draw_cmd_exec.sv
// Directed bench for draw_cmd_exec with a command-level model of expected tile writes
// and overlay commands, plus literal timing and value checks.
`timescale 1ns/1ps
module tb_draw_cmd_exec;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cmd = '0;
  logic        cmd_vld = 1'b0;
  logic        fb_we;
  logic [9:0]  fb_addr;
  logic [7:0]  fb_wdata;
  logic [63:0] ovl_cmd;
  logic        ovl_vld;
  logic        ovl_rdy = 1'b1;
  logic        busy;
  logic        overflow;
  logic        err_cmd;

  int n_tests = 0;
  int n_fail  = 0;

  logic [17:0] exp_fb[$];
  logic [63:0] exp_ovl[$];
  bit          exp_err = 0;
  bit          exp_ovf = 0;
  bit          has_w0 = 0;
  logic [31:0] w0 = '0;

  always #5 clk = ~clk;

  draw_cmd_exec dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cmd),
    .cmd_vld  (cmd_vld),
    .fb_we    (fb_we),
    .fb_addr  (fb_addr),
    .fb_wdata (fb_wdata),
    .ovl_cmd  (ovl_cmd),
    .ovl_vld  (ovl_vld),
    .ovl_rdy  (ovl_rdy),
    .busy     (busy),
    .overflow (overflow),
    .err_cmd  (err_cmd)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] mk_point(input logic [4:0] x, input logic [4:0] y,
                                           input logic [7:0] c);
    return {4'h0, x, y, c, 10'b0};
  endfunction

  function automatic logic [31:0] mk_fill(input logic [4:0] x0, input logic [4:0] y0,
                                          input logic [4:0] x1, input logic [4:0] y1,
                                          input logic [7:0] c);
    return {4'h1, x0, y0, x1, y1, c};
  endfunction

  // Command semantics: what each accepted word must eventually cause.
  function automatic void model_word(input logic [31:0] w);
    logic [3:0] op;
    int x0, x1, y0, y1;
    op = w[31:28];
    if (has_w0) begin
      has_w0 = 0;
      if (op == w0[31:28] && w[0]) begin
        exp_ovl.push_back({w0, w});
        return;
      end
      exp_err = 1;
    end
    case (op)
      4'h0: begin
        x0 = int'(w[27:23]);
        y0 = int'(w[22:18]);
        if (x0 <= 31 && y0 <= 23) exp_fb.push_back({w[22:18], w[27:23], w[17:10]});
      end
      4'h1: begin
        x0 = int'(w[27:23]); y0 = int'(w[22:18]);
        x1 = int'(w[17:13]); y1 = int'(w[12:8]);
        for (int y = (y0 < y1 ? y0 : y1); y <= (y0 < y1 ? y1 : y0); y++)
          for (int x = (x0 < x1 ? x0 : x1); x <= (x0 < x1 ? x1 : x0); x++)
            if (x <= 31 && y <= 23) exp_fb.push_back({5'(y), 5'(x), w[7:0]});
      end
      4'h9, 4'hA: begin
        if (!w[0]) begin
          has_w0 = 1;
          w0 = w;
        end else begin
          exp_err = 1;
        end
      end
      default: exp_err = 1;
    endcase
  endfunction

  task automatic push(input logic [31:0] w, input bit accepted);
    cmd = w;
    cmd_vld = 1'b1;
    if (accepted) model_word(w);
    else exp_ovf = 1;
    @(posedge clk); #1;
    cmd_vld = 1'b0;
  endtask

  task automatic clear_model();
    exp_fb.delete();
    exp_ovl.delete();
    has_w0 = 0;
    exp_err = 0;
    exp_ovf = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    cmd_vld = 1'b0;
    clear_model();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int i;
    i = 0;
    while ((busy || fb_we || ovl_vld) && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    if (busy || fb_we || ovl_vld) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: still active after %0d cycles, required idle", name, budget);
    end
  endtask

  task automatic wait_fb_we(input string name, input int budget);
    int i;
    i = 0;
    while (!fb_we && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    if (!fb_we) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_no_write: fb_we=0 after %0d cycles, required 1", name, budget);
    end
  endtask

  task automatic end_check(input string name);
    check({name, "_fb_pending"}, 64'(exp_fb.size()), 64'd0);
    check({name, "_ovl_pending"}, 64'(exp_ovl.size()), 64'd0);
    check({name, "_err_cmd"}, 64'(err_cmd), 64'(exp_err));
    check({name, "_overflow"}, 64'(overflow), 64'(exp_ovf));
  endtask

  // Every write and every overlay handshake is matched against the model in order.
  always @(negedge clk) begin
    if (!rst) begin
      if (fb_we) begin
        if (exp_fb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL fb_unexpected_write: addr=%0h data=%0h, required no write", fb_addr, fb_wdata);
        end else begin
          check("fb_write", 64'({fb_addr, fb_wdata}), 64'(exp_fb.pop_front()));
        end
      end
      if (ovl_vld && exp_ovl.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL ovl_unexpected: ovl_vld=1 cmd=%0h, required ovl_vld=0", ovl_cmd);
      end else if (ovl_vld && ovl_rdy) begin
        check("ovl_cmd", ovl_cmd, exp_ovl.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, first, second, t;
    logic [9:0] first_addr, last_addr;

    do_reset();
    check("rst_fb_we", 64'(fb_we), 64'd0);
    check("rst_fb_addr", 64'(fb_addr), 64'd0);
    check("rst_fb_wdata", 64'(fb_wdata), 64'd0);
    check("rst_ovl_vld", 64'(ovl_vld), 64'd0);
    check("rst_ovl_cmd", ovl_cmd, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_err_cmd", 64'(err_cmd), 64'd0);

    // Single point latency: pushed at edge k, written in the cycle after edge k+2.
    cmd = mk_point(5'd3, 5'd5, 8'h0F);
    cmd_vld = 1'b1;
    model_word(cmd);
    @(posedge clk); #1;
    cmd_vld = 1'b0;
    check("pt_lat_k", 64'(fb_we), 64'd0);
    @(posedge clk); #1;
    check("pt_lat_k1", 64'(fb_we), 64'd0);
    @(posedge clk); #1;
    check("pt_lat_k2", 64'(fb_we), 64'd1);
    check("pt_addr", 64'(fb_addr), 64'h0A3);
    check("pt_data", 64'(fb_wdata), 64'h0F);
    @(posedge clk); #1;
    check("pt_single", 64'(fb_we), 64'd0);
    check("pt_addr_hold", 64'(fb_addr), 64'h0A3);
    wait_idle("point", 20);
    end_check("point");

    // Back-to-back points: one write every two cycles.
    push(mk_point(5'd7, 5'd1, 8'h21), 1);
    push(mk_point(5'd8, 5'd1, 8'h22), 1);
    first = -1;
    second = -1;
    t = 0;
    repeat (10) begin
      if (fb_we) begin
        if (first < 0) first = t;
        else if (second < 0) second = t;
      end
      @(posedge clk); #1;
      t++;
    end
    check("b2b_gap", 64'(second - first), 64'd2);
    wait_idle("b2b", 20);
    end_check("b2b");

    // Full-screen fill.
    push(mk_fill(5'd0, 5'd0, 5'd31, 5'd23, 8'hFF), 1);
    wait_fb_we("fill", 20);
    first_addr = fb_addr;
    last_addr = fb_addr;
    cnt = 0;
    while (fb_we && cnt < 1000) begin
      last_addr = fb_addr;
      cnt++;
      @(posedge clk); #1;
    end
    check("fill_count", 64'(cnt), 64'd768);
    check("fill_first_addr", 64'(first_addr), 64'h000);
    check("fill_last_addr", 64'(last_addr), 64'h2FF);
    check("fill_busy_fall", 64'(busy), 64'd0);
    end_check("fill");

    // Swapped corners reaching past the last legal row: 15 cells, 9 written, 1+15 busy cycles.
    push(mk_fill(5'd5, 5'd25, 5'd3, 5'd21, 8'h11), 1);
    cnt = 0;
    while (busy && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("fill_skip_cycles", 64'(cnt), 64'd16);
    wait_idle("fill_swap", 20);
    end_check("fill_swap");

    push(mk_point(5'd4, 5'd30, 8'h33), 1);
    wait_idle("pt_oob", 20);
    end_check("pt_oob");

    // Char pair held against a stalled renderer.
    ovl_rdy = 1'b0;
    push(32'hA123_4560, 1);
    push(32'hA123_4561, 1);
    cnt = 0;
    while (!ovl_vld && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("ovl_vld_rise", 64'(ovl_vld), 64'd1);
    check("ovl_cmd_lit", ovl_cmd, 64'hA123_4560_A123_4561);
    repeat (5) begin
      @(posedge clk); #1;
      check("ovl_vld_hold", 64'(ovl_vld), 64'd1);
      check("ovl_cmd_stable", ovl_cmd, 64'hA123_4560_A123_4561);
      check("ovl_no_fb", 64'(fb_we), 64'd0);
    end
    ovl_rdy = 1'b1;
    @(posedge clk); #1;
    check("ovl_drop", 64'(ovl_vld), 64'd0);
    wait_idle("char", 20);
    end_check("char");

    // Broken pair, then an unknown opcode.
    push(32'h9000_0AB0, 1);
    push(mk_point(5'd1, 5'd1, 8'h22), 1);
    wait_idle("broken_pair", 20);
    check("err_broken_pair", 64'(err_cmd), 64'd1);
    end_check("broken_pair");
    push(32'h5000_0000, 1);
    wait_idle("bad_op", 20);
    check("err_sticky", 64'(err_cmd), 64'd1);
    end_check("bad_op");

    do_reset();
    push(32'h9000_0001, 1);
    wait_idle("lone_second", 20);
    check("err_lone_second", 64'(err_cmd), 64'd1);
    end_check("lone_second");

    // 20 words during a long fill: the FIFO keeps 16, drops 4.
    push(mk_fill(5'd0, 5'd0, 5'd31, 5'd23, 8'h5A), 1);
    wait_fb_we("ovf_fill", 20);
    for (int i = 0; i < 20; i++)
      push(mk_point(5'(i), 5'(i), 8'(8'h80 + i)), (i < 16));
    check("ovf_flag", 64'(overflow), 64'd1);
    wait_idle("overflow", 3000);
    end_check("overflow");

    // Reset in the middle of a fill with words still queued.
    do_reset();
    push(mk_fill(5'd0, 5'd0, 5'd31, 5'd23, 8'h77), 1);
    wait_fb_we("rst_fill", 20);
    cnt = 1;
    while (cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    push(mk_point(5'd2, 5'd2, 8'h01), 1);
    push(mk_point(5'd3, 5'd3, 8'h02), 1);
    rst = 1'b1;
    clear_model();
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_fb_we", 64'(fb_we), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    repeat (5) begin
      @(posedge clk); #1;
      check("midrst_quiet", 64'(fb_we), 64'd0);
    end
    push(mk_point(5'd9, 5'd9, 8'h99), 1);
    wait_idle("after_reset", 20);
    end_check("after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
